// File: rtl/roomterminal_pkg.sv
// Shared definitions for the room terminal serial link (receiver and transmitter).
package roomterminal_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned BAUD       = 115_200;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // Clock divider rounded to the nearest integer.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Emits a one-cycle tick every DIV clocks; clr holds the divider at zero so the
// tick phase restarts from the release of clr.
module baud_tick_gen #(
    parameter int unsigned CLK_HZ     = roomterminal_pkg::CLK_HZ,
    parameter int unsigned BAUD       = roomterminal_pkg::BAUD,
    parameter int unsigned OVERSAMPLE = roomterminal_pkg::OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV = roomterminal_pkg::calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = wrap && !clr;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled start detection and a one-entry holding
// register drained through a ready/ack handshake.
module uart_rx #(
    parameter int unsigned CLK_HZ     = roomterminal_pkg::CLK_HZ,
    parameter int unsigned BAUD       = roomterminal_pkg::BAUD,
    parameter int unsigned OVERSAMPLE = roomterminal_pkg::OVERSAMPLE
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset,
    input  logic       RxD,
    input  logic       RxD_ack,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       rx_busy
);

    import roomterminal_pkg::*;

    localparam int unsigned HALF = OVERSAMPLE / 2;
    localparam int unsigned TW   = $clog2(OVERSAMPLE);

    logic           sync1_q, rxs_q;
    uart_rx_state_t state_q, state_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           deliver_q, deliver_d;
    logic           ferr_q, ferr_d;
    logic [7:0]     data_q, data_d;
    logic           ready_q, ready_d;
    logic           ovr_q, ovr_d;
    logic           tick;

    baud_tick_gen #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (FPGA_CLK1_50),
        .reset (reset),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: if (tick) begin
                if (tcnt_q == TW'(HALF - 1)) begin
                    tcnt_d = '0;
                    bcnt_d = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            DATA: if (tick) begin
                if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
                    tcnt_d  = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = STOP;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            STOP: if (tick) begin
                if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
                    tcnt_d = '0;
                    if (rxs_q) begin
                        deliver_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            BREAK: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A byte arriving while the register is full only lands if the consumer
    // drains the old one in that same cycle.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        if (deliver_q) begin
            if (!ready_q || RxD_ack) begin
                data_d  = shift_q;
                ready_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ready_q && RxD_ack) begin
            ready_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            // NOTE: synchronizer flops reset to the idle line level so leaving
            // reset never looks like a start edge.
            sync1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= RxD;
            rxs_q     <= sync1_q;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
            ferr_q    <= ferr_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
        end
    end

    assign RxD_data       = data_q;
    assign RxD_data_ready = ready_q;
    assign framing_err    = ferr_q;
    assign overrun        = ovr_q;
    assign rx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames on RxD and checks the holding
// register, handshake, error flags and ready latency against hand-worked values.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NOM  = 434;   // 50 MHz / 115200
    localparam int BIT_FAST = 426;   // baud * 1.02
    localparam int BIT_SLOW = 443;   // baud * 0.98
    localparam int LATENCY  = 4107;  // 2 sync + 152 ticks * 27 + 1

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_cnt = 0;

    uart_rx dut (
        .FPGA_CLK1_50   (clk),
        .reset          (reset),
        .RxD            (rxd),
        .RxD_ack        (ack),
        .RxD_data       (data),
        .RxD_data_ready (ready),
        .framing_err    (ferr),
        .overrun        (ovr),
        .rx_busy        (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (ferr === 1'b1) ferr_cnt = ferr_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    // Leaves rxd at the stop-bit level when it returns (on a falling clock edge).
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (per) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk) ack = 1'b1;
        @(posedge clk);
        @(negedge clk) ack = 1'b0;
    endtask

    task automatic test_reset();
        rxd = 1'b1;
        ack = 1'b0;
        do_reset();
        n_checks++; if (data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", data); end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++; if (ferr !== 1'b0) begin n_errors++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        n_checks++; if (ovr !== 1'b0) begin n_errors++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_byte();
        int f0;
        f0 = ferr_cnt;
        fork
            send_frame(8'hA5, BIT_NOM, 1'b1);
            begin
                repeat (1000) @(posedge clk);
                @(negedge clk);
                n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL a5_busy_mid: got %b expected 1", busy); end
            end
            begin
                repeat (LATENCY) @(posedge clk);
                @(negedge clk);
                n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL a5_ready_early: got %b expected 0", ready); end
                @(posedge clk);
                @(negedge clk);
                n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL a5_ready_latency: got %b expected 1", ready); end
                n_checks++; if (data !== 8'hA5) begin n_errors++; $display("FAIL a5_data: got %h expected a5", data); end
            end
        join
        n_checks++; if (ferr_cnt - f0 != 0) begin n_errors++; $display("FAIL a5_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
        n_checks++; if (ovr !== 1'b0) begin n_errors++; $display("FAIL a5_ovr: got %b expected 0", ovr); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL a5_busy_end: got %b expected 0", busy); end
        n_checks++; if (ready !== 1'b1 || data !== 8'hA5) begin n_errors++; $display("FAIL a5_hold: got ready=%b data=%h expected 1/a5", ready, data); end
    endtask

    task automatic test_ack();
        pulse_ack();
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL ack_clears: got %b expected 0", ready); end
        pulse_ack();
        n_checks++; if (ready !== 1'b0 || ovr !== 1'b0) begin n_errors++; $display("FAIL ack_idle: got ready=%b ovr=%b expected 0/0", ready, ovr); end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy: got %b expected 1", busy); end
        repeat (49) @(posedge clk);
        @(negedge clk) rxd = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_idle: got %b expected 0", busy); end
        n_checks++; if (ready !== 1'b0 || ovr !== 1'b0) begin n_errors++; $display("FAIL glitch_out: got ready=%b ovr=%b expected 0/0", ready, ovr); end
        n_checks++; if (ferr_cnt - f0 != 0) begin n_errors++; $display("FAIL glitch_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
        send_frame(8'h3C, BIT_NOM, 1'b1);
        n_checks++; if (ready !== 1'b1 || data !== 8'h3C) begin n_errors++; $display("FAIL glitch_next: got ready=%b data=%h expected 1/3c", ready, data); end
        pulse_ack();
    endtask

    task automatic test_framing();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h00, BIT_NOM, 1'b0);
        repeat (2 * BIT_NOM) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL break_busy: got %b expected 1", busy); end
        rxd = 1'b1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ferr_cnt - f0 != 1) begin n_errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", ferr_cnt - f0); end
        n_checks++; if (ready !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL ferr_nodata: got ready=%b busy=%b expected 0/0", ready, busy); end
        send_frame(8'h55, BIT_NOM, 1'b1);
        n_checks++; if (ready !== 1'b1 || data !== 8'h55) begin n_errors++; $display("FAIL after_break: got ready=%b data=%h expected 1/55", ready, data); end
        n_checks++; if (ferr_cnt - f0 != 1) begin n_errors++; $display("FAIL after_break_ferr: got %0d pulses expected 1", ferr_cnt - f0); end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h31, BIT_NOM, 1'b1);
        n_checks++; if (ready !== 1'b1 || data !== 8'h31 || ovr !== 1'b0) begin n_errors++; $display("FAIL b2b_first: got ready=%b data=%h ovr=%b expected 1/31/0", ready, data, ovr); end
        send_frame(8'h32, BIT_NOM, 1'b1);
        n_checks++; if (data !== 8'h31) begin n_errors++; $display("FAIL b2b_data: got %h expected 31", data); end
        n_checks++; if (ready !== 1'b1 || ovr !== 1'b1) begin n_errors++; $display("FAIL b2b_overrun: got ready=%b ovr=%b expected 1/1", ready, ovr); end
    endtask

    task automatic test_ack_in_delivery();
        do_reset();
        n_checks++; if (ovr !== 1'b0 || ready !== 1'b0) begin n_errors++; $display("FAIL ovr_reset: got ovr=%b ready=%b expected 0/0", ovr, ready); end
        send_frame(8'h31, BIT_NOM, 1'b1);
        n_checks++; if (ready !== 1'b1 || data !== 8'h31) begin n_errors++; $display("FAIL ackdel_first: got ready=%b data=%h expected 1/31", ready, data); end
        fork
            send_frame(8'h32, BIT_NOM, 1'b1);
            begin
                repeat (LATENCY) @(posedge clk);
                @(negedge clk) ack = 1'b1;
                @(posedge clk);
                @(negedge clk) ack = 1'b0;
                n_checks++; if (ready !== 1'b1 || data !== 8'h32) begin n_errors++; $display("FAIL ackdel_load: got ready=%b data=%h expected 1/32", ready, data); end
            end
        join
        n_checks++; if (ovr !== 1'b0 || ready !== 1'b1 || data !== 8'h32) begin n_errors++; $display("FAIL ackdel_end: got ovr=%b ready=%b data=%h expected 0/1/32", ovr, ready, data); end
        pulse_ack();
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL ackdel_drain: got %b expected 0", ready); end
    endtask

    task automatic test_reset_midframe();
        int f0;
        f0 = ferr_cnt;
        fork
            send_frame(8'hF0, BIT_NOM, 1'b1);
            begin
                repeat (2400) @(posedge clk);
                @(negedge clk) reset = 1'b1;
                @(posedge clk);
                @(negedge clk) reset = 1'b0;
            end
        join
        repeat (4500) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL partial_drop: got ready=%b busy=%b expected 0/0", ready, busy); end
        n_checks++; if (data !== 8'h00 || ovr !== 1'b0) begin n_errors++; $display("FAIL partial_state: got data=%h ovr=%b expected 00/0", data, ovr); end
        send_frame(8'h7E, BIT_FAST, 1'b1);
        n_checks++; if (ready !== 1'b1 || data !== 8'h7E) begin n_errors++; $display("FAIL fast_7e: got ready=%b data=%h expected 1/7e", ready, data); end
        pulse_ack();
        send_frame(8'h7E, BIT_SLOW, 1'b1);
        n_checks++; if (ready !== 1'b1 || data !== 8'h7E) begin n_errors++; $display("FAIL slow_7e: got ready=%b data=%h expected 1/7e", ready, data); end
        n_checks++; if (ferr_cnt - f0 != 0 || ovr !== 1'b0) begin n_errors++; $display("FAIL skew_errs: got ferr=%0d ovr=%b expected 0/0", ferr_cnt - f0, ovr); end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_ack();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_ack_in_delivery();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
